ca_state_sequencer: RTL and testbench

Read-modify-write sequencer for the per-neuron calcium SRAM words {state_calcium[2:0], state_caleak_cnt[4:0]}. It sits on the SRAM side of the calcium/AD update logic. It fetches a neuron's stored state and presents it to the update logic. It then captures the returned next-state values and writes them back. Two job types exist: a full sweep of all neurons on each time-reference request, and a single-neuron update for each spike request.

---
 rtl/ca_state_sequencer.sv | 158 +++++++++++++++
 tb/tb_ca_state_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_state_sequencer.sv
// Calcium SRAM read-modify-write sequencer.
// Runs full-array leak sweeps and single-neuron spike updates.
module ca_state_sequencer #(
  parameter int N_NEUR = 256,
  parameter int AW     = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          tref_req,
  input  logic          spk_req,
  input  logic [AW-1:0] spk_addr,
  output logic          spk_ack,
  output logic          busy,
  output logic          sweep_done,
  output logic          tref_overrun,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_wdata,
  input  logic [7:0]    sram_rdata,
  output logic [2:0]    mdl_state_calcium,
  output logic [4:0]    mdl_state_caleak_cnt,
  output logic          mdl_event_tref,
  output logic          mdl_spike,
  input  logic [2:0]    mdl_calcium_next,
  input  logic [4:0]    mdl_caleak_cnt_next
);

  typedef enum logic [2:0] {
    IDLE, RD, LAT, EVAL, WR
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(N_NEUR - 1);

  state_t        state_q, state_d;
  logic          spk_job_q, spk_job_d;
  logic          sweep_q, sweep_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          done_q, done_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    ca_q, ca_d;
  logic [4:0]    lk_q, lk_d;
  logic [7:0]    wdata_q, wdata_d;

  logic sweep_wr, last_wr, sweep_live, start;

  always_comb begin
    state_d   = state_q;
    spk_job_d = spk_job_q;
    sweep_d   = sweep_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    ca_d      = ca_q;
    lk_d      = lk_q;
    wdata_d   = wdata_q;
    spk_ack   = 1'b0;
    start     = 1'b0;

    sweep_wr   = (state_q == WR) && !spk_job_q;
    last_wr    = sweep_wr && (cnt_q == LAST);
    sweep_live = sweep_q && !last_wr;

    if (sweep_wr) cnt_d = last_wr ? '0 : cnt_q + 1'b1;
    if (last_wr) begin
      sweep_d = 1'b0;
      done_d  = 1'b1;
    end

    case (state_q)
      RD:   state_d = LAT;
      LAT: begin
        ca_d    = sram_rdata[7:5];
        lk_d    = sram_rdata[4:0];
        state_d = EVAL;
      end
      EVAL: begin
        wdata_d = {mdl_calcium_next, mdl_caleak_cnt_next};
        state_d = WR;
      end
      // IDLE and neuron boundary: pick the next job
      default: begin
        if (spk_req) begin
          spk_ack   = 1'b1;
          spk_job_d = 1'b1;
          addr_d    = spk_addr;
          state_d   = RD;
        end else if (sweep_live) begin
          spk_job_d = 1'b0;
          addr_d    = cnt_d;
          state_d   = RD;
        end else if (pend_q || tref_req) begin
          start     = 1'b1;
          spk_job_d = 1'b0;
          sweep_d   = 1'b1;
          cnt_d     = '0;
          addr_d    = '0;
          state_d   = RD;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    // a request consumed by a direct start is not re-latched
    if (start) begin
      pend_d = pend_q & tref_req;
    end else if (tref_req) begin
      if (pend_q) ovr_d = 1'b1;
      else        pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      spk_job_q <= 1'b0;
      sweep_q   <= 1'b0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      ca_q      <= '0;
      lk_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      spk_job_q <= spk_job_d;
      sweep_q   <= sweep_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      ca_q      <= ca_d;
      lk_q      <= lk_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy                 = (state_q != IDLE);
  assign sweep_done           = done_q;
  assign tref_overrun         = ovr_q;
  assign sram_cs              = (state_q == RD) || (state_q == WR);
  assign sram_we              = (state_q == WR);
  assign sram_addr            = addr_q;
  assign sram_wdata           = wdata_q;
  assign mdl_state_calcium    = ca_q;
  assign mdl_state_caleak_cnt = lk_q;
  assign mdl_event_tref       = (state_q == EVAL) && !spk_job_q;
  assign mdl_spike            = (state_q == EVAL) && spk_job_q;

endmodule

// File: tb/tb_ca_state_sequencer.sv
// Bench for ca_state_sequencer with N_NEUR=4.
// SRAM accesses are scoreboarded against a queue of expected accesses.
module tb_ca_state_sequencer;

  localparam int AW = 8;
  localparam int N  = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } acc_t;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          tref_req = 1'b0;
  logic          spk_req = 1'b0;
  logic [AW-1:0] spk_addr = '0;
  logic          spk_ack, busy, sweep_done, tref_overrun;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_wdata, sram_rdata;
  logic [2:0]    mdl_state_calcium, mdl_calcium_next;
  logic [4:0]    mdl_state_caleak_cnt, mdl_caleak_cnt_next;
  logic          mdl_event_tref, mdl_spike;

  ca_state_sequencer #(.N_NEUR(N), .AW(AW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .tref_req(tref_req), .spk_req(spk_req), .spk_addr(spk_addr),
    .spk_ack(spk_ack), .busy(busy), .sweep_done(sweep_done),
    .tref_overrun(tref_overrun),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .mdl_state_calcium(mdl_state_calcium),
    .mdl_state_caleak_cnt(mdl_state_caleak_cnt),
    .mdl_event_tref(mdl_event_tref), .mdl_spike(mdl_spike),
    .mdl_calcium_next(mdl_calcium_next),
    .mdl_caleak_cnt_next(mdl_caleak_cnt_next)
  );

  always #5 CLK = ~CLK;

  // update logic: spike bumps calcium, tref bumps the leak counter
  assign mdl_calcium_next = mdl_spike ?
    mdl_state_calcium + 3'd1 : mdl_state_calcium;
  assign mdl_caleak_cnt_next = mdl_event_tref ?
    mdl_state_caleak_cnt + 5'd1 : mdl_state_caleak_cnt;

  logic [7:0]    mem [256];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_data = '0;

  always @(posedge CLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  int   checks = 0;
  int   errors = 0;
  int   n_tref = 0;
  int   n_spk  = 0;
  int   n_done = 0;
  acc_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_rd(input logic [AW-1:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, data: 8'h00});
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
    exp_q.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  task automatic push_rmw(input logic [AW-1:0] a, input logic [7:0] d);
    push_rd(a);
    push_wr(a, d);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // monitor: every SRAM access must match the head of the queue
  initial forever begin
    @(negedge CLK);
    if (RSTN) begin
      if (sram_cs) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: we=%0b addr=%0h",
                   sram_we, sram_addr);
        end else begin
          acc_t e;
          e = exp_q.pop_front();
          chk("acc_we", 32'(sram_we), 32'(e.we));
          chk("acc_addr", 32'(sram_addr), 32'(e.addr));
          if (e.we) chk("acc_wdata", 32'(sram_wdata), 32'(e.data));
        end
      end
      if (mdl_event_tref && mdl_spike) begin
        checks++;
        errors++;
        $display("FAIL eval_both: tref=1 spike=1 required one-hot");
      end
      if (mdl_event_tref) n_tref++;
      if (mdl_spike)      n_spk++;
      if (sweep_done)     n_done++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] pa [5];
    logic [7:0]    pd [5];
    int bc, w, t0, s0, d0;
    pa = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7};
    pd = '{8'h00, 8'h21, 8'h5F, 8'h45, 8'hA0};

    for (int i = 0; i < 5; i++) begin
      pre_addr = pa[i];
      pre_data = pd[i];
      pre_we   = 1'b1;
      tick();
    end
    pre_we = 1'b0;

    // reset values
    @(negedge CLK);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cs", 32'(sram_cs), 0);
    chk("rst_bus", {sram_we, sram_addr, sram_wdata}, 0);
    chk("rst_flags", {spk_ack, sweep_done, tref_overrun}, 0);
    chk("rst_mdl", {mdl_state_calcium, mdl_state_caleak_cnt,
                    mdl_event_tref, mdl_spike}, 0);
    tick();
    RSTN = 1'b1;
    @(negedge CLK);

    // single spike on address 3: 8'h45 -> 8'h65
    push_rmw(8'd3, 8'h65);
    tick(); spk_addr = 8'd3; spk_req = 1'b1;
    @(negedge CLK);
    chk("spk_ack_sel", 32'(spk_ack), 1);
    chk("spk_busy_sel", 32'(busy), 0);
    tick(); spk_req = 1'b0;
    @(negedge CLK);
    chk("spk_ack_pulse", 32'(spk_ack), 0);
    chk("spk_busy_rd", 32'(busy), 1);
    tick(); @(negedge CLK);
    tick(); @(negedge CLK);
    chk("spk_ca", 32'(mdl_state_calcium), 2);
    chk("spk_cnt", 32'(mdl_state_caleak_cnt), 5);
    chk("spk_eval", {mdl_spike, mdl_event_tref}, 2'b10);
    tick(); @(negedge CLK);
    chk("spk_wr_nospike", 32'(mdl_spike), 0);
    tick(); @(negedge CLK);
    chk("spk_idle", 32'(busy), 0);
    chk("spk_mem3", 32'(mem[3]), 32'h65);
    chk("spk_q_empty", exp_q.size(), 0);

    // full sweep, leak counter +1 on each neuron
    t0 = n_tref; d0 = n_done;
    push_rmw(8'd0, 8'h01);
    push_rmw(8'd1, 8'h22);
    push_rmw(8'd2, 8'h40);
    push_rmw(8'd3, 8'h66);
    tick(); tref_req = 1'b1;
    @(negedge CLK);
    chk("sw_busy_sel", 32'(busy), 0);
    tick(); tref_req = 1'b0;
    @(negedge CLK);
    bc = 0;
    while (busy && bc < 40) begin
      bc++;
      @(negedge CLK);
    end
    chk("sw_cycles", bc, 16);
    chk("sw_done", 32'(sweep_done), 1);
    @(negedge CLK);
    chk("sw_done_pulse", 32'(sweep_done), 0);
    chk("sw_done_cnt", n_done - d0, 1);
    chk("sw_tref_cnt", n_tref - t0, 4);
    chk("sw_q_empty", exp_q.size(), 0);

    // spike on address 7 raised during neuron 1 RD
    t0 = n_tref; s0 = n_spk;
    push_rmw(8'd0, 8'h02);
    push_rmw(8'd1, 8'h23);
    push_rmw(8'd7, 8'hC0);
    push_rmw(8'd2, 8'h41);
    push_rmw(8'd3, 8'h67);
    tick(); tref_req = 1'b1;
    @(negedge CLK);
    tick(); tref_req = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge CLK);
    end
    tick(); spk_addr = 8'd7; spk_req = 1'b1;
    @(negedge CLK);
    chk("ss_rd1", {sram_cs, sram_we, sram_addr}, {2'b10, 8'd1});
    w = 0;
    while (!spk_ack && w < 10) begin
      @(negedge CLK);
      w++;
    end
    chk("ss_ack_delay", w, 3);
    chk("ss_ack_at_wr1", {sram_we, sram_addr}, {1'b1, 8'd1});
    tick(); spk_req = 1'b0;
    @(negedge CLK);
    bc = 0;
    while (busy && bc < 40) begin
      bc++;
      @(negedge CLK);
    end
    chk("ss_cycles", bc, 12);
    @(negedge CLK);
    chk("ss_spk_cnt", n_spk - s0, 1);
    chk("ss_tref_cnt", n_tref - t0, 4);
    chk("ss_q_empty", exp_q.size(), 0);

    // overrun: back-to-back sweeps, third request dropped
    d0 = n_done;
    push_rmw(8'd0, 8'h03);
    push_rmw(8'd1, 8'h24);
    push_rmw(8'd2, 8'h42);
    push_rmw(8'd3, 8'h68);
    push_rmw(8'd0, 8'h04);
    push_rmw(8'd1, 8'h25);
    push_rmw(8'd2, 8'h43);
    push_rmw(8'd3, 8'h69);
    bc = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      tref_req = (k == 0 || k == 3 || k == 6);
      @(negedge CLK);
      if (k == 3) chk("ov_early", 32'(tref_overrun), 0);
      if (k == 7) chk("ov_set", 32'(tref_overrun), 1);
      if (busy) bc++;
      else if (k > 0) break;
    end
    tref_req = 1'b0;
    chk("ov_cycles", bc, 32);
    @(negedge CLK);
    chk("ov_done_cnt", n_done - d0, 2);
    chk("ov_sticky", 32'(tref_overrun), 1);
    chk("ov_q_empty", exp_q.size(), 0);

    // simultaneous spike and tref in IDLE
    push_rmw(8'd2, 8'h63);
    push_rmw(8'd0, 8'h05);
    push_rmw(8'd1, 8'h26);
    push_rmw(8'd2, 8'h64);
    push_rmw(8'd3, 8'h6A);
    tick(); tref_req = 1'b1; spk_req = 1'b1; spk_addr = 8'd2;
    @(negedge CLK);
    chk("sim_ack", 32'(spk_ack), 1);
    tick(); tref_req = 1'b0; spk_req = 1'b0;
    @(negedge CLK);
    bc = 0;
    while (busy && bc < 40) begin
      bc++;
      @(negedge CLK);
    end
    chk("sim_cycles", bc, 20);
    chk("sim_ovr_sticky", 32'(tref_overrun), 1);
    chk("sim_q_empty", exp_q.size(), 0);

    // reset during EVAL of sweep neuron 2
    push_rmw(8'd0, 8'h06);
    push_rmw(8'd1, 8'h27);
    push_rd(8'd2);
    tick(); tref_req = 1'b1;
    @(negedge CLK);
    tick(); tref_req = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      tick(); @(negedge CLK);
    end
    chk("rm_eval2", {mdl_event_tref, sram_addr}, {1'b1, 8'd2});
    #1 RSTN = 1'b0;
    #1;
    chk("rm_cs", 32'(sram_cs), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_mdl", {mdl_state_calcium, mdl_state_caleak_cnt,
                   mdl_event_tref, mdl_spike}, 0);
    chk("rm_ovr", 32'(tref_overrun), 0);
    tick(); tick();
    RSTN = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge CLK);
    chk("rm_idle", 32'(busy), 0);
    chk("rm_mem2", 32'(mem[2]), 32'h64);
    chk("rm_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
